// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 multiply / divide controller producing a MIPS-style HI/LO pair.
// One result bit per cycle: shift-add multiply, restoring shift-subtract divide.
// Build option: define MULT_DIV_CTRL_DIV_EN to include the divide datapath;
// without it, DIV/DIVU complete with normal latency and return zeros.
module mult_div_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    localparam int unsigned W         = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAST_ITER = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2*W-1:0]     acc_q,   acc_d;
    logic [W-1:0]       opnd_q,  opnd_d;
    logic               div_q,   div_d;
    logic               neg_q,   neg_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [W-1:0]       hi_q,    hi_d;
    logic [W-1:0]       lo_q,    lo_d;
    logic               dbz_q,   dbz_d;
`ifdef MULT_DIV_CTRL_DIV_EN
    logic               rneg_q,  rneg_d;
    logic [W-1:0]       araw_q,  araw_d;
    logic [W:0]         div_sh;
    logic               div_ge;
    logic [W-1:0]       div_rem;
    logic [W-1:0]       quo_fix;
    logic [W-1:0]       rem_fix;
`endif

    logic               accept;
    logic               is_signed;
    logic [W-1:0]       abs_a;
    logic [W-1:0]       abs_b;
    logic [W:0]         mul_sum;
    logic [2*W-1:0]     prod_fix;

    // Next-state, datapath step and result formatting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        accept    = start && ((state_q == IDLE) || (state_q == DONE));
        is_signed = ~op[0];
        abs_a     = (is_signed && opA[W-1]) ? -opA : opA;
        abs_b     = (is_signed && opB[W-1]) ? -opB : opB;
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
        prod_fix  = neg_q ? -acc_q : acc_q;
`ifdef MULT_DIV_CTRL_DIV_EN
        rneg_d    = rneg_q;
        araw_d    = araw_q;
        div_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = div_sh >= {1'b0, opnd_q};
        div_rem   = div_ge ? W'(div_sh - {1'b0, opnd_q}) : div_sh[W-1:0];
        quo_fix   = neg_q  ? -acc_q[W-1:0]     : acc_q[W-1:0];
        rem_fix   = rneg_q ? -acc_q[2*W-1:W]   : acc_q[2*W-1:W];
`endif

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    div_d   = op[1];
                    neg_d   = is_signed & (opA[W-1] ^ opB[W-1]);
`ifdef MULT_DIV_CTRL_DIV_EN
                    rneg_d  = is_signed & opA[W-1];
                    araw_d  = opA;
                    if (op[1]) begin
                        acc_d  = {W'(0), abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {W'(0), abs_b};
                        opnd_d = abs_a;
                    end
`else
                    acc_d   = {W'(0), abs_b};
                    opnd_d  = abs_a;
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef MULT_DIV_CTRL_DIV_EN
                if (div_q) acc_d = {div_rem, acc_q[W-2:0], div_ge};
                else       acc_d = {mul_sum, acc_q[W-1:1]};
`else
                acc_d = {mul_sum, acc_q[W-1:1]};
`endif
                if (cnt_q == CNT_W'(LAST_ITER)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef MULT_DIV_CTRL_DIV_EN
                if (div_q) begin
                    if (opnd_q == '0) begin
                        hi_d  = araw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d  = rem_fix;
                        lo_d  = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
`else
                if (div_q) begin
                    hi_d = '0;
                    lo_d = '0;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
`ifdef MULT_DIV_CTRL_DIV_EN
            rneg_q  <= 1'b0;
            araw_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
`ifdef MULT_DIV_CTRL_DIV_EN
            rneg_q  <= rneg_d;
            araw_q  <= araw_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
